mux_lut_cell: RTL and testbench

Parametrised programmable logic cell: an N-input lookup table evaluated through a 2:1 mux tree, with a serially loaded truth table and a registered, valid-qualified output. It is the configurable successor to the fixed mux-built gates. One instance can be loaded to act as AND, OR, XOR, majority or any other N-input function, and its truth table can be reprogrammed at run time without disturbing evaluation.

---
 rtl/mux_lut_cell.sv | 104 ++++++++++
 tb/tb_mux_lut_cell.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_lut_cell.sv
// mux_lut_cell: N-input programmable lookup table.
// The active truth table is read through a binary 2:1 mux tree indexed by x.
// A new table is shifted in serially, MSB first, behind the active one.
// It replaces the active table in a single edge once all W bits are in.
// Evaluation is registered and valid-qualified with one cycle of latency.
// Legal N_IN range is 1..6.

module mux_lut_cell #(
    parameter int                   N_IN        = 2,
    parameter logic [(2**N_IN)-1:0] RESET_TABLE = 4'b1000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_valid,
    input  logic            cfg_bit,
    output logic            cfg_busy,
    output logic            cfg_done,
    input  logic            in_valid,
    input  logic [N_IN-1:0] x,
    output logic            out_valid,
    output logic            y
);

    localparam int W  = 2 ** N_IN;
    localparam int CW = $clog2(W) + 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    // Active table used for evaluation.
    logic [W-1:0]  table_a;

    // The shadow register only keeps the W-1 most recent bits. Once a full
    // table is in, the oldest bit would fall off on the next shift, so it is
    // never observable. The bit arriving on the commit edge completes the
    // table, taken directly from cfg_bit.
    logic [W-2:0]  shadow;
    logic [CW-1:0] cnt;

    // Shadow contents after the current bit is shifted in. On the final bit
    // of a load this is exactly the table to commit.
    logic [W-1:0]  shift_next;
    logic          last_bit;

    // Mux tree nodes, packed level by level.
    //   Level 0 occupies the W leaves, which are the active table.
    //   Level k+1 holds W>>(k+1) nodes, selected by x[k].
    //   The root sits at index 2W-2.
    logic [2*W-2:0] node;
    logic           tree_out;

    assign shift_next = {shadow, cfg_bit};
    assign last_bit   = (cnt == CNT_LAST);
    assign cfg_busy   = (cnt != '0);

    // Serial table load: shift, count, and commit atomically on the W-th bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            table_a  <= RESET_TABLE;
            shadow   <= '0;
            cnt      <= '0;
            cfg_done <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            if (cfg_valid) begin
                shadow <= shift_next[W-2:0];
                if (last_bit) begin
                    table_a  <= shift_next;
                    cnt      <= '0;
                    cfg_done <= 1'b1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

    // Build the mux tree. Each level halves the candidate set, using one bit of x.
    assign node[W-1:0] = table_a;

    for (genvar k = 0; k < N_IN; k++) begin : g_lvl
        localparam int OFF_IN  = 2 * W - ((2 * W) >> k);
        localparam int OFF_OUT = 2 * W - (W >> k);
        for (genvar i = 0; i < (W >> (k + 1)); i++) begin : g_mux
            assign node[OFF_OUT + i] = x[k] ? node[OFF_IN + 2 * i + 1]
                                            : node[OFF_IN + 2 * i];
        end
    end

    assign tree_out = node[2 * W - 2];

    // Registered evaluation. y holds its value across cycles with no operand.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            y         <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                y <= tree_out;
            end
        end
    end

endmodule

// File: tb/tb_mux_lut_cell.sv
// Directed bench for mux_lut_cell.
// A 2-input instance covers reset, reprogramming, commit collisions and
// mid-load reset. A 3-input instance covers the majority function with
// operand gaps.

module tb_mux_lut_cell;

    logic       clk;
    logic       rst_n;

    logic       cfg_valid;
    logic       cfg_bit;
    logic       cfg_busy;
    logic       cfg_done;
    logic       in_valid;
    logic [1:0] x;
    logic       out_valid;
    logic       y;

    logic       c3_cfg_valid;
    logic       c3_cfg_bit;
    logic       c3_cfg_busy;
    logic       c3_cfg_done;
    logic       c3_in_valid;
    logic [2:0] c3_x;
    logic       c3_out_valid;
    logic       c3_y;

    int pass_cnt;
    int total_cnt;

    mux_lut_cell #(
        .N_IN        (2),
        .RESET_TABLE (4'b1000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done),
        .in_valid  (in_valid),
        .x         (x),
        .out_valid (out_valid),
        .y         (y)
    );

    mux_lut_cell #(
        .N_IN        (3),
        .RESET_TABLE (8'b1000_0000)
    ) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (c3_cfg_valid),
        .cfg_bit   (c3_cfg_bit),
        .cfg_busy  (c3_cfg_busy),
        .cfg_done  (c3_cfg_done),
        .in_valid  (c3_in_valid),
        .x         (c3_x),
        .out_valid (c3_out_valid),
        .y         (c3_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_bit   = 1'b0;
        in_valid  = 1'b1;
        x         = 2'b11;
        tick();
        tick();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (y !== 1'b0) $display("FAIL reset_y got %b want 0", y);
        else pass_cnt++;
        total_cnt++;
        if (cfg_busy !== 1'b0 || cfg_done !== 1'b0)
            $display("FAIL reset_cfg got busy=%b done=%b want 0 0", cfg_busy, cfg_done);
        else pass_cnt++;
        rst_n = 1'b1;
        begin
            logic [3:0] exp_and;
            exp_and = 4'b1000;
            for (int i = 0; i < 4; i++) begin
                x        = 2'(i);
                in_valid = 1'b1;
                tick();
                total_cnt++;
                if (out_valid !== 1'b1 || y !== exp_and[i])
                    $display("FAIL and_default x=%0d got v=%b y=%b want v=1 y=%b",
                             i, out_valid, y, exp_and[i]);
                else pass_cnt++;
            end
        end
        in_valid = 1'b0;
        tick();
        total_cnt++;
        if (out_valid !== 1'b0 || y !== 1'b1)
            $display("FAIL idle_hold got v=%b y=%b want v=0 y=1", out_valid, y);
        else pass_cnt++;
    endtask

    task automatic test_xor();
        logic [3:0] bits;
        bits = 4'b0110;
        for (int i = 3; i >= 0; i--) begin
            cfg_valid = 1'b1;
            cfg_bit   = bits[i];
            tick();
            total_cnt++;
            if (i > 0) begin
                if (cfg_busy !== 1'b1 || cfg_done !== 1'b0)
                    $display("FAIL xor_load_bit%0d got busy=%b done=%b want 1 0",
                             4 - i, cfg_busy, cfg_done);
                else pass_cnt++;
            end else begin
                if (cfg_busy !== 1'b0 || cfg_done !== 1'b1)
                    $display("FAIL xor_commit got busy=%b done=%b want 0 1", cfg_busy, cfg_done);
                else pass_cnt++;
            end
        end
        cfg_valid = 1'b0;
        tick();
        total_cnt++;
        if (cfg_done !== 1'b0) $display("FAIL xor_done_pulse got %b want 0", cfg_done);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            x        = 2'(i);
            in_valid = 1'b1;
            tick();
            total_cnt++;
            if (out_valid !== 1'b1 || y !== bits[i])
                $display("FAIL xor_eval x=%0d got v=%b y=%b want v=1 y=%b",
                         i, out_valid, y, bits[i]);
            else pass_cnt++;
        end
        in_valid = 1'b0;
    endtask

    // Load OR (1110) with the final bit coinciding with operand cx.
    // The result on that edge comes from the old AND table.
    task automatic test_collision();
        logic [3:0] or_bits;
        logic [1:0] coll_x [2];
        logic       exp_old [2];
        or_bits    = 4'b1110;
        coll_x[0]  = 2'b11;
        exp_old[0] = 1'b1;
        coll_x[1]  = 2'b01;
        exp_old[1] = 1'b0;
        for (int r = 0; r < 2; r++) begin
            do_reset();
            for (int i = 3; i >= 1; i--) begin
                cfg_valid = 1'b1;
                cfg_bit   = or_bits[i];
                tick();
            end
            cfg_bit  = or_bits[0];
            in_valid = 1'b1;
            x        = coll_x[r];
            tick();
            total_cnt++;
            if (y !== exp_old[r] || cfg_done !== 1'b1)
                $display("FAIL collision_old x=%0d got y=%b done=%b want y=%b done=1",
                         coll_x[r], y, cfg_done, exp_old[r]);
            else pass_cnt++;
            cfg_valid = 1'b0;
            x         = 2'b01;
            tick();
            total_cnt++;
            if (y !== 1'b1 || out_valid !== 1'b1)
                $display("FAIL collision_new x=1 got y=%b v=%b want y=1 v=1", y, out_valid);
            else pass_cnt++;
            in_valid = 1'b0;
        end
    endtask

    task automatic test_pause_reset();
        logic [3:0] nand_bits;
        nand_bits = 4'b0111;
        do_reset();
        cfg_valid = 1'b1;
        cfg_bit   = 1'b1;
        tick();
        cfg_bit   = 1'b0;
        tick();
        cfg_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total_cnt++;
            if (cfg_busy !== 1'b1 || cfg_done !== 1'b0)
                $display("FAIL pause_idle%0d got busy=%b done=%b want 1 0", i, cfg_busy, cfg_done);
            else pass_cnt++;
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total_cnt++;
        if (cfg_busy !== 1'b0) $display("FAIL midload_reset_busy got %b want 0", cfg_busy);
        else pass_cnt++;
        in_valid = 1'b1;
        x        = 2'b01;
        tick();
        total_cnt++;
        if (y !== 1'b0) $display("FAIL restored_and x=1 got %b want 0", y);
        else pass_cnt++;
        x = 2'b11;
        tick();
        total_cnt++;
        if (y !== 1'b1) $display("FAIL restored_and x=3 got %b want 1", y);
        else pass_cnt++;
        in_valid = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            cfg_valid = 1'b1;
            cfg_bit   = nand_bits[i];
            tick();
            total_cnt++;
            if (cfg_done !== (i == 0))
                $display("FAIL reload_done_bit%0d got %b want %b", 4 - i, cfg_done, (i == 0));
            else pass_cnt++;
        end
        cfg_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            x        = 2'(i);
            tick();
            total_cnt++;
            if (y !== nand_bits[i])
                $display("FAIL reload_eval x=%0d got %b want %b", i, y, nand_bits[i]);
            else pass_cnt++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_majority();
        logic [7:0] maj;
        logic [7:0] gap_before;
        logic       exp_y;
        maj        = 8'b1110_1000;
        gap_before = 8'b1011_0001;
        exp_y      = 1'b0;
        c3_in_valid = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            c3_cfg_valid = 1'b1;
            c3_cfg_bit   = maj[i];
            tick();
        end
        c3_cfg_valid = 1'b0;
        total_cnt++;
        if (c3_cfg_done !== 1'b1 || c3_cfg_busy !== 1'b0)
            $display("FAIL maj_commit got done=%b busy=%b want 1 0", c3_cfg_done, c3_cfg_busy);
        else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            if (gap_before[i]) begin
                c3_in_valid = 1'b0;
                c3_x        = 3'($urandom_range(0, 7));
                tick();
                total_cnt++;
                if (c3_out_valid !== 1'b0 || c3_y !== exp_y)
                    $display("FAIL maj_gap before x=%0d got v=%b y=%b want v=0 y=%b",
                             i, c3_out_valid, c3_y, exp_y);
                else pass_cnt++;
            end
            c3_in_valid = 1'b1;
            c3_x        = 3'(i);
            exp_y       = (i == 3 || i == 5 || i == 6 || i == 7);
            tick();
            total_cnt++;
            if (c3_out_valid !== 1'b1 || c3_y !== exp_y)
                $display("FAIL maj_eval x=%0d got v=%b y=%b want v=1 y=%b",
                         i, c3_out_valid, c3_y, exp_y);
            else pass_cnt++;
        end
        c3_in_valid = 1'b0;
    endtask

    initial begin
        pass_cnt     = 0;
        total_cnt    = 0;
        c3_cfg_valid = 1'b0;
        c3_cfg_bit   = 1'b0;
        c3_in_valid  = 1'b0;
        c3_x         = 3'b000;
        test_reset();
        test_xor();
        test_collision();
        test_pause_reset();
        test_majority();
        tick();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
